// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg -- shared definitions for the RV32I instruction-fetch stage.
//   if_state_e : FSM encoding (IF_FETCH issues byte reads, IF_HOLD presents
//                the assembled instruction to decode)
//   INST_BYTES : number of byte reads per 32-bit instruction
package if_fetch_pkg;

   typedef enum logic {
      IF_FETCH = 1'b0,
      IF_HOLD  = 1'b1
   } if_state_e;

   localparam int INST_BYTES = 4;

endpackage

// File: rtl/if_fetch.sv
// if_fetch -- instruction-fetch stage. Owns the PC, fetches each 32-bit
// instruction as four little-endian byte reads from the shared byte-wide
// memory port and presents {pc, inst} to decode with a valid/ready handshake.
// Redirects from later stages squash any fetch in flight.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_re/mem_addr       byte-read request (combinational from state)
//   mem_gnt               request accepted this cycle
//   mem_rdata             read byte, valid the cycle after a granted request
//   br_en/br_target       redirect pulse and target address
//   if_valid/if_ready     IF/ID handshake
//   if_pc/if_inst         fetched instruction and its address
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [7:0]        mem_rdata,
   input  logic              br_en,
   input  logic [ADDR_W-1:0] br_target,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_inst
);

   if_state_e         r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [2:0]        r_req_idx;  // next byte to request (0..4)
   logic [1:0]        r_rsp_idx;  // next byte to capture (0..3)
   logic              r_pending;  // a granted byte returns this cycle
   logic [23:0]       r_buf;      // bytes 0..2; byte 3 goes straight to if_inst
   logic              r_if_valid;
   logic [ADDR_W-1:0] r_if_pc;
   logic [31:0]       r_if_inst;

   logic              w_req;
   logic              w_last;

   assign w_req    = (r_state == IF_FETCH) && (r_req_idx < 3'(INST_BYTES));
   // Gate with rst so nothing reaches the arbiter during a reset cycle.
   assign mem_re   = w_req && !rst;
   assign mem_addr = r_pc + ADDR_W'(r_req_idx);
   assign w_last   = r_pending && (r_rsp_idx == 2'(INST_BYTES - 1));

   assign if_valid = r_if_valid;
   assign if_pc    = r_if_pc;
   assign if_inst  = r_if_inst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IF_FETCH;
         r_pc       <= RESET_PC;
         r_req_idx  <= '0;
         r_rsp_idx  <= '0;
         r_pending  <= 1'b0;
         r_buf      <= '0;
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_inst  <= '0;
      end else if (br_en) begin
         // Clearing r_pending drops whatever byte returns next cycle, so a
         // request granted in this same cycle is harmlessly ignored.
         r_state    <= IF_FETCH;
         r_pc       <= {br_target[ADDR_W-1:2], 2'b00};
         r_req_idx  <= '0;
         r_rsp_idx  <= '0;
         r_pending  <= 1'b0;
         r_if_valid <= 1'b0;
      end else begin
         case (r_state)
            IF_FETCH: begin
               if (mem_re && mem_gnt) begin
                  r_req_idx <= r_req_idx + 3'd1;
                  r_pending <= 1'b1;
               end else begin
                  r_pending <= 1'b0;
               end
               if (r_pending) begin
                  r_rsp_idx <= r_rsp_idx + 2'd1;
                  case (r_rsp_idx)
                     2'd0:    r_buf[7:0]   <= mem_rdata;
                     2'd1:    r_buf[15:8]  <= mem_rdata;
                     2'd2:    r_buf[23:16] <= mem_rdata;
                     default: ;
                  endcase
               end
               if (w_last) begin
                  r_if_inst  <= {mem_rdata, r_buf};
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_state    <= IF_HOLD;
               end
            end
            IF_HOLD: begin
               // No prefetch: the next fetch starts only after the handoff.
               r_pending <= 1'b0;
               if (r_if_valid && if_ready) begin
                  r_pc       <= r_pc + ADDR_W'(INST_BYTES);
                  r_if_valid <= 1'b0;
                  r_req_idx  <= '0;
                  r_rsp_idx  <= '0;
                  r_state    <= IF_FETCH;
               end
            end
            default: r_state <= IF_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic        mem_re;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic [7:0]  mem_rdata;
   logic        br_en;
   logic [31:0] br_target;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int checks = 0;
   int errors = 0;

   if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
      .br_en(br_en), .br_target(br_target),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: fixed first word, hashed bytes elsewhere.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] x;
      case (a)
         32'd0: return 8'h13;
         32'd1: return 8'h05;
         32'd2: return 8'hA0;
         32'd3: return 8'h00;
         default: begin
            x = a[7:0] * 8'd29 + 8'h5B;
            return x ^ a[15:8] ^ a[31:24];
         end
      endcase
   endfunction

   function automatic logic [31:0] word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   // Byte-wide memory: data one cycle after a granted request, garbage otherwise.
   always @(posedge clk)
      mem_rdata <= (mem_re && mem_gnt) ? mem_byte(mem_addr) : 8'($urandom);

   // One reset cycle; returns at the start of c0 with rst already low.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; br_en = 1'b0; br_target = '0; mem_gnt = 1'b1; if_ready = 1'b1;
      #1;
      checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rst_no_req: mem_re=%b exp 0", mem_re); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", if_pc); end
      checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", if_inst); end
      checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: re=%b addr=%h exp 1/0", mem_re, mem_addr); end
   endtask

   task automatic test_basic();
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (c <= 3) begin
            checks++; if (mem_re !== 1'b1 || mem_addr !== 32'(c)) begin errors++; $display("FAIL basic_req c%0d: re=%b addr=%h exp 1/%h", c, mem_re, mem_addr, c); end
         end
         if (c == 4) begin
            checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL basic_idle c4: re=%b exp 0", mem_re); end
         end
         if (c == 5 || c == 11) begin
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL basic_valid c%0d: got %b exp 1", c, if_valid); end
            checks++; if (if_pc !== ((c == 5) ? 32'h0 : 32'h4)) begin errors++; $display("FAIL basic_pc c%0d: got %h", c, if_pc); end
            checks++; if (if_inst !== ((c == 5) ? 32'h00A00513 : word(32'h4))) begin errors++; $display("FAIL basic_inst c%0d: got %h exp %h", c, if_inst, (c == 5) ? 32'h00A00513 : word(32'h4)); end
         end else begin
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL basic_novalid c%0d: got %b exp 0", c, if_valid); end
         end
         if (c == 6) begin
            checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL basic_next c6: re=%b addr=%h exp 1/4", mem_re, mem_addr); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         if (c > 0) @(negedge clk);
         if_ready = (c >= 8);
         #1;
         if (c >= 5 && c <= 8) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h00A00513)
               begin errors++; $display("FAIL bp_hold c%0d: v=%b pc=%h inst=%h exp 1/0/00a00513", c, if_valid, if_pc, if_inst); end
            checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL bp_no_prefetch c%0d: re=%b exp 0", c, mem_re); end
         end
         if (c == 9) begin
            checks++; if (if_valid !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'h4)
               begin errors++; $display("FAIL bp_release: v=%b re=%b addr=%h exp 0/1/4", if_valid, mem_re, mem_addr); end
         end
      end
   endtask

   task automatic test_gnt_stall();
      logic [31:0] exp_addr [0:4];
      exp_addr = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd3};
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) @(negedge clk);
         mem_gnt = (c != 2);
         #1;
         if (c <= 4) begin
            checks++; if (mem_re !== 1'b1 || mem_addr !== exp_addr[c]) begin errors++; $display("FAIL stall_req c%0d: re=%b addr=%h exp 1/%h", c, mem_re, mem_addr, exp_addr[c]); end
         end
         if (c == 5) begin
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stall_early c5: v=%b exp 0", if_valid); end
         end
         if (c == 6) begin
            checks++; if (if_valid !== 1'b1 || if_inst !== 32'h00A00513 || if_pc !== 32'h0)
               begin errors++; $display("FAIL stall_inst c6: v=%b pc=%h inst=%h exp 1/0/00a00513", if_valid, if_pc, if_inst); end
         end
      end
      mem_gnt = 1'b1;
   endtask

   task automatic test_redirect();
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) @(negedge clk);
         br_en = (c == 2);
         br_target = 32'h103;
         #1;
         if (c >= 3 && c <= 6) begin
            checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h100 + 32'(c - 3)) begin errors++; $display("FAIL br_req c%0d: re=%b addr=%h exp 1/%h", c, mem_re, mem_addr, 32'h100 + 32'(c - 3)); end
         end
         if (c == 7) begin
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_early c7: v=%b exp 0", if_valid); end
         end
         if (c == 8) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== word(32'h100))
               begin errors++; $display("FAIL br_inst c8: v=%b pc=%h inst=%h exp 1/100/%h", if_valid, if_pc, if_inst, word(32'h100)); end
         end
      end
      br_en = 1'b0;
   endtask

   task automatic test_br_transfer();
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) @(negedge clk);
         br_en = (c == 5);
         br_target = 32'h208;
         #1;
         if (c == 5) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL brx_handshake c5: v=%b pc=%h exp 1/0", if_valid, if_pc); end
         end
         if (c == 6) begin
            checks++; if (if_valid !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'h208)
               begin errors++; $display("FAIL brx_target c6: v=%b re=%b addr=%h exp 0/1/208", if_valid, mem_re, mem_addr); end
         end
         if (c == 11) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h208 || if_inst !== word(32'h208))
               begin errors++; $display("FAIL brx_inst c11: v=%b pc=%h inst=%h exp 1/208/%h", if_valid, if_pc, if_inst, word(32'h208)); end
         end
      end
      br_en = 1'b0;
   endtask

   task automatic test_rst_mid();
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         if (c > 0) @(negedge clk);
         rst = (c == 8);
         #1;
         if (c == 8) begin
            checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rstmid_re c8: re=%b exp 0", mem_re); end
         end
         if (c == 9) begin
            checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0)
               begin errors++; $display("FAIL rstmid_clear c9: v=%b pc=%h inst=%h exp 0/0/0", if_valid, if_pc, if_inst); end
            checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_restart c9: re=%b addr=%h exp 1/0", mem_re, mem_addr); end
         end
         if (c == 14) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h00A00513)
               begin errors++; $display("FAIL rstmid_inst c14: v=%b pc=%h inst=%h", if_valid, if_pc, if_inst); end
         end
      end
   endtask

   // Transaction-level model: expected PC of the next delivered instruction,
   // and how many byte reads of it have been accepted so far.
   task automatic test_random();
      logic [31:0] exp_pc;
      int          grants, idle, max_idle, xfers;
      logic        prev_hold;
      logic [31:0] prev_pc, prev_inst;
      exp_pc = 32'h0; grants = 0; idle = 0; max_idle = 0; xfers = 0; prev_hold = 1'b0;
      prev_pc = '0; prev_inst = '0;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if (i > 0) @(negedge clk);
         mem_gnt  = ($urandom_range(0, 3) != 0);
         if_ready = ($urandom_range(0, 4) < 3);
         br_en    = ($urandom_range(0, 29) == 0);
         br_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
         #1;
         if (prev_hold) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== prev_pc || if_inst !== prev_inst)
               begin errors++; $display("FAIL rnd_hold i%0d: v=%b pc=%h inst=%h exp 1/%h/%h", i, if_valid, if_pc, if_inst, prev_pc, prev_inst); end
         end
         if (if_valid === 1'b1) begin
            checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rnd_prefetch i%0d: re=%b exp 0", i, mem_re); end
         end
         if (mem_re === 1'b1) begin
            checks++; if (mem_addr !== exp_pc + 32'(grants)) begin errors++; $display("FAIL rnd_addr i%0d: got %h exp %h", i, mem_addr, exp_pc + 32'(grants)); end
         end
         if (if_valid === 1'b1 && if_ready) begin
            checks++; if (if_pc !== exp_pc || if_inst !== word(exp_pc))
               begin errors++; $display("FAIL rnd_xfer i%0d: pc=%h inst=%h exp %h/%h", i, if_pc, if_inst, exp_pc, word(exp_pc)); end
         end
         prev_hold = (if_valid === 1'b1) && !if_ready && !br_en;
         prev_pc = if_pc; prev_inst = if_inst;
         // Effect of the coming edge.
         if (if_valid === 1'b1 && if_ready) xfers++;
         if (br_en) begin
            exp_pc = {br_target[31:2], 2'b00}; grants = 0; idle = 0;
         end else if (if_valid === 1'b1 && if_ready) begin
            exp_pc = exp_pc + 32'd4; grants = 0; idle = 0;
         end else begin
            if (mem_re === 1'b1 && mem_gnt) grants++;
            idle++;
         end
         if (idle > max_idle) max_idle = idle;
         if (idle > 60) break;
      end
      checks++; if (max_idle > 60) begin errors++; $display("FAIL rnd_liveness: %0d cycles without progress, limit 60", max_idle); end
      checks++; if (xfers < 20) begin errors++; $display("FAIL rnd_throughput: %0d transfers, need >= 20", xfers); end
      br_en = 1'b0; mem_gnt = 1'b1; if_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; mem_gnt = 1'b1; br_en = 1'b0; br_target = '0; if_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_gnt_stall();
      test_redirect();
      test_br_transfer();
      test_rst_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, sitting directly upstream of the decode stage. It owns the PC and reads each 32-bit instruction from the byte-wide unified memory port as four little-endian byte reads. It presents {pc, inst} to the IF/ID boundary with a valid/ready handshake. Taken branches and jumps from later stages redirect it and squash any fetch in flight.

Parameters:
ADDR_W, 32, width of the PC and the memory address.
RESET_PC, 0, PC loaded on reset; must be 4-byte aligned.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
mem_re  out  1  byte-read request
mem_addr  out  ADDR_W  byte address of the request
mem_gnt  in  1  request accepted this cycle (arbiter shared with load/store)
mem_rdata  in  8  read byte; valid exactly one cycle after a cycle with mem_re && mem_gnt
br_en  in  1  redirect pulse from a later stage
br_target  in  ADDR_W  redirect address
if_valid  out  1  if_pc/if_inst hold a fetched instruction
if_ready  in  1  downstream accepts the instruction (transfer when if_valid && if_ready)
if_pc  out  ADDR_W  address of if_inst
if_inst  out  32  fetched instruction

Behaviour:
- Priority at each edge: rst > br_en > normal operation.
- Reset values: pc=RESET_PC, state=FETCH, req_idx=0, rsp_idx=0, pending=0, if_valid=0, if_inst=0, if_pc=0.
- mem_re and mem_addr are combinational from registered state. No request is issued in a cycle where rst=1.
- FETCH state:
  - mem_re=(req_idx<4); mem_addr=pc+req_idx.
  - On mem_re && mem_gnt: req_idx++ and pending<=1; otherwise pending<=0.
  - When mem_gnt=0, the request is retried next cycle with mem_addr unchanged.
- Capture: when pending=1, mem_rdata is written to byte rsp_idx, then rsp_idx++.
  - Byte 0 goes to inst[7:0], byte 3 to inst[31:24].
- Completion: on the edge capturing byte 3, register the following and move to HOLD:
  - if_inst <= {mem_rdata, b2, b1, b0}
  - if_pc <= pc
  - if_valid <= 1
- HOLD state:
  - mem_re=0; if_valid, if_pc and if_inst are held stable.
  - On if_valid && if_ready: pc<=pc+4 (wraps mod 2^ADDR_W), if_valid<=0, req/rsp_idx<=0, state FETCH.
- Timing: with mem_gnt=1, the first request is issued in cycle c0 after reset deasserts.
  - if_valid is high in c5.
  - With if_ready=1, the steady-state period is 6 cycles per instruction.
  - There is no prefetch during HOLD.
- Redirect: br_en=1 in any state sets, at that edge:
  - pc <= {br_target[ADDR_W-1:2], 2'b00}
  - req_idx, rsp_idx and pending <= 0
  - if_valid <= 0, state FETCH
  - Any byte returning in the following cycle is discarded, and fetch restarts at the target next cycle.
- br_en coincident with a transfer: the transfer occurs on the handshake, but the next pc is the target, not pc+4.
- br_en in the cycle a request is granted: the grant is honoured by memory, but its data is ignored.
- rst mid-fetch: all in-flight progress is abandoned and the reset values apply.

Decomposition:
- defines.v gains IF_FETCH/IF_HOLD state encodings, `InstBytes (4), and the reset PC default.
- `InstAddrBus/`InstBus are reused for if_pc/if_inst when ADDR_W=32.
- No sub-module: the byte-assembly buffer, index counters and FSM are small enough to stay in one module.

Test Plan:
- Reset, mem[0..3]=13 05 A0 00, gnt=1, ready=1 -> mem_addr 0,1,2,3 in c0-c3; c5 if_valid=1, if_inst=0x00A00513, if_pc=0; next if_valid at c11 with if_pc=4.
- Back-pressure: if_ready=0 for 3 cycles after c5 -> if_valid/if_pc/if_inst stable, mem_re=0; on ready=1 the transfer occurs and mem_addr=4 the next cycle.
- mem_gnt=0 in c2 -> mem_addr=2 on c2 and c3, if_valid first at c6, if_inst still correct.
- br_en in c2 with br_target=0x103 -> c3 mem_addr=0x100, stale byte ignored; valid instruction has if_pc=0x100 and bytes 0x100-0x103.
- br_en=1 together with if_valid && if_ready at pc=0 -> if_valid=0 next cycle, next fetch at br_target, never 4.
- rst asserted in c3 of a fetch -> the following cycle if_valid=0, if_inst=0, mem_re=0 during rst, and restart at RESET_PC.
